// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared widths and issuer state encodings for the ALU operand issuer
package alu_defs;

  localparam int ALU_OPW  = 8;
  localparam int ALU_RESW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// rtl/alu_resp_fifo.sv - synchronous response FIFO with count, power-of-2 depth
module alu_resp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the response bus is clean after reset.
  assign pop_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - issues one operand pair to an ALU unit, waits LATENCY, queues the tagged result
module alu_op_issuer
  import alu_defs::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OPW-1:0]  req_a,
  input  logic [ALU_OPW-1:0]  req_b,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [ALU_OPW-1:0]  alu_a,
  output logic [ALU_OPW-1:0]  alu_b,
  output logic                alu_start,
  input  logic [ALU_RESW-1:0] alu_res,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_RESW-1:0] rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  issuer_state_t              state;
  issuer_state_t              next_state;
  logic [3:0]                 wait_cnt;
  logic [TAG_W-1:0]           tag_q;
  logic                       accept;
  logic                       capture;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [ALU_RESW+TAG_W-1:0]  fifo_head;

  assign accept  = req_valid && req_ready;
  assign capture = (state == WAIT) && (wait_cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_cnt == 4'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = (fifo_count < CW'(DEPTH));
        busy      = 1'b0;
      end
      ISSUE:   alu_start = 1'b1;
      default: ;
    endcase
  end

  // Operands hold between accepts; the counter only moves while an op is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      tag_q    <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        alu_a <= req_a;
        alu_b <= req_b;
        tag_q <= req_tag;
      end
      if (state == ISSUE)     wait_cnt <= 4'(LATENCY);
      else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  alu_resp_fifo #(
    .WIDTH (ALU_RESW + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data ({alu_res, tag_q}),
    .pop       (rsp_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rsp_valid           = !fifo_empty;
  assign {rsp_data, rsp_tag} = fifo_head;

  // Accept requires space and nothing else pushes while in flight, so capture never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(capture && fifo_full));

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed bench for alu_op_issuer at LATENCY 1 and 3
module tb_alu_op_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv1 = 0, rsp_ready1 = 0;
  logic [7:0]  ra1 = 0, rb1 = 0;
  logic [1:0]  rt1 = 0;
  logic        req_ready1, alu_start1, rsp_valid1, busy1;
  logic [7:0]  alu_a1, alu_b1;
  logic [15:0] alu_res1, rsp_data1;
  logic [1:0]  rsp_tag1;

  logic        rv3 = 0, rsp_ready3 = 0;
  logic [7:0]  ra3 = 0, rb3 = 0;
  logic [1:0]  rt3 = 0;
  logic        req_ready3, alu_start3, rsp_valid3, busy3;
  logic [7:0]  alu_a3, alu_b3;
  logic [15:0] alu_res3, rsp_data3;
  logic [1:0]  rsp_tag3;

  // Unit stubs: result is only meaningful in the capture cycle, garbage otherwise.
  logic       sh1 = 1'b0;
  logic [2:0] sh3 = 3'b000;
  always @(posedge clk) begin
    sh1 <= alu_start1;
    sh3 <= {sh3[1:0], alu_start3};
  end
  assign alu_res1 = sh1    ? {8'h00, alu_a1 & alu_b1} : 16'hDEAD;
  assign alu_res3 = sh3[2] ? {alu_a3, alu_b3}         : 16'hBEEF;

  alu_op_issuer #(.LATENCY(1), .DEPTH(4), .TAG_W(2)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(req_ready1),
    .req_a(ra1), .req_b(rb1), .req_tag(rt1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_start(alu_start1), .alu_res(alu_res1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1), .busy(busy1)
  );

  alu_op_issuer #(.LATENCY(3), .DEPTH(4), .TAG_W(2)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(req_ready3),
    .req_a(ra3), .req_b(rb3), .req_tag(rt3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_start(alu_start3), .alu_res(alu_res3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_tag(rsp_tag3), .busy(busy3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request to the LATENCY=1 unit and return in the cycle after it is accepted.
  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
    bit done;
    done = 0;
    rv1 = 1; ra1 = a; rb1 = b; rt1 = t;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready1) done = 1;
      tick;
    end
    rv1 = 0;
    if (!done) check_vec("issue1_timeout", 0, 1);
  endtask

  task automatic pop_check1(input string tag, input logic [15:0] d, input logic [1:0] t);
    check_vec({tag, "_valid"}, rsp_valid1, 1);
    check_vec({tag, "_data"}, rsp_data1, d);
    check_vec({tag, "_tag"}, rsp_tag1, t);
    rsp_ready1 = 1;
    tick;
    rsp_ready1 = 0;
  endtask

  logic [17:0] exp_q[$];
  int          sent, got;
  bit          acc, pop;

  initial begin
    tick; tick;
    rst = 0;
    check_vec("rst_ready", req_ready1, 1);
    check_vec("rst_rsp_valid", rsp_valid1, 0);
    check_vec("rst_start", alu_start1, 0);
    check_vec("rst_busy", busy1, 0);
    check_vec("rst_alu_ab", {alu_a1, alu_b1}, 16'h0000);
    check_vec("rst_rsp", {rsp_data1, rsp_tag1}, 18'h0);

    // Single op at LATENCY=1 against an AND unit.
    rv1 = 1; ra1 = 8'hF0; rb1 = 8'h3C; rt1 = 2'd1;
    check_vec("t1_c0_start", alu_start1, 0);
    tick; rv1 = 0;
    check_vec("t1_c1_start", alu_start1, 1);
    check_vec("t1_c1_busy", busy1, 1);
    check_vec("t1_c1_ready", req_ready1, 0);
    check_vec("t1_c1_ab", {alu_a1, alu_b1}, 16'hF03C);
    tick;
    check_vec("t1_c2_start", alu_start1, 0);
    check_vec("t1_c2_rsp_valid", rsp_valid1, 0);
    check_vec("t1_c2_ready", req_ready1, 0);
    tick;
    check_vec("t1_c3_ready", req_ready1, 1);
    check_vec("t1_c3_busy", busy1, 0);
    check_vec("t1_c3_ab_hold", {alu_a1, alu_b1}, 16'hF03C);
    pop_check1("t1_rsp", 16'h0030, 2'd1);
    check_vec("t1_empty", rsp_valid1, 0);

    // LATENCY=3 with a {a,b} stub: capture must land on start+3.
    rv3 = 1; ra3 = 8'h12; rb3 = 8'h34; rt3 = 2'd2;
    tick; rv3 = 0;
    for (int c = 1; c <= 4; c++) begin
      check_vec($sformatf("t2_c%0d_ready", c), req_ready3, 0);
      check_vec($sformatf("t2_c%0d_start", c), alu_start3, (c == 1) ? 1 : 0);
      check_vec($sformatf("t2_c%0d_rsp_valid", c), rsp_valid3, 0);
      tick;
    end
    check_vec("t2_c5_ready", req_ready3, 1);
    check_vec("t2_c5_valid", rsp_valid3, 1);
    check_vec("t2_c5_data", rsp_data3, 16'h1234);
    check_vec("t2_c5_tag", rsp_tag3, 2'd2);
    rsp_ready3 = 1; tick; rsp_ready3 = 0;
    check_vec("t2_empty", rsp_valid3, 0);

    // Backpressure: four results fill the FIFO, the fifth waits for one pop.
    for (int i = 0; i < 4; i++) issue1(8'hFF, 8'(8'h11 * (i + 1)), 2'(i));
    tick; tick;
    check_vec("t3_count_full", u_l1.fifo_count, 4);
    check_vec("t3_ready_full", req_ready1, 0);
    check_vec("t3_head_tag", rsp_tag1, 2'd0);
    rv1 = 1; ra1 = 8'hF0; rb1 = 8'h5A; rt1 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_vec("t3_held_ready", req_ready1, 0);
    end
    rsp_ready1 = 1; tick; rsp_ready1 = 0;
    check_vec("t3_ready_after_pop", req_ready1, 1);
    tick; rv1 = 0;
    tick; tick;
    pop_check1("t3_r1", 16'h0022, 2'd1);
    pop_check1("t3_r2", 16'h0033, 2'd2);
    pop_check1("t3_r3", 16'h0044, 2'd3);
    pop_check1("t3_r4", 16'h0050, 2'd0);
    check_vec("t3_empty", rsp_valid1, 0);

    // Push and pop on the same edge with two entries queued.
    issue1(8'hFF, 8'h40, 2'd0);
    issue1(8'hFF, 8'h41, 2'd1);
    tick; tick;
    check_vec("t4_count_pre", u_l1.fifo_count, 2);
    issue1(8'hFF, 8'h42, 2'd2);
    tick;
    check_vec("t4_head0", rsp_tag1, 2'd0);
    rsp_ready1 = 1; tick; rsp_ready1 = 0;
    check_vec("t4_count_a", u_l1.fifo_count, 2);
    check_vec("t4_head1", rsp_tag1, 2'd1);
    issue1(8'hFF, 8'h43, 2'd3);
    tick;
    check_vec("t4_head1b", rsp_tag1, 2'd1);
    rsp_ready1 = 1; tick; rsp_ready1 = 0;
    check_vec("t4_count_b", u_l1.fifo_count, 2);
    pop_check1("t4_r2", 16'h0042, 2'd2);
    pop_check1("t4_r3", 16'h0043, 2'd3);
    check_vec("t4_empty", rsp_valid1, 0);

    // Reset one cycle after start at LATENCY=3, with an older result still queued.
    rv3 = 1; ra3 = 8'hAA; rb3 = 8'h55; rt3 = 2'd3;
    tick; rv3 = 0;
    tick; tick; tick; tick;
    check_vec("t5_prior_data", rsp_data3, 16'hAA55);
    rv3 = 1; ra3 = 8'h11; rb3 = 8'h22; rt3 = 2'd1;
    tick; rv3 = 0;
    check_vec("t5_start", alu_start3, 1);
    tick;
    rst = 1;
    tick;
    rst = 0;
    check_vec("t5_rst_rsp_valid", rsp_valid3, 0);
    check_vec("t5_rst_busy", busy3, 0);
    check_vec("t5_rst_start", alu_start3, 0);
    check_vec("t5_rst_count", u_l3.fifo_count, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_vec("t5_no_stale", rsp_valid3, 0);
    end
    rv3 = 1; ra3 = 8'hAB; rb3 = 8'hCD; rt3 = 2'd2;
    tick; rv3 = 0;
    tick; tick; tick; tick;
    check_vec("t5_new_valid", rsp_valid3, 1);
    check_vec("t5_new_data", rsp_data3, 16'hABCD);
    check_vec("t5_new_tag", rsp_tag3, 2'd2);
    rsp_ready3 = 1; tick; rsp_ready3 = 0;

    // Streaming: req_valid held high, eight random ops, responses drained as they come.
    sent = 0; got = 0;
    rsp_ready1 = 1;
    rv1 = 1; ra1 = 8'($urandom); rb1 = 8'($urandom); rt1 = 2'd0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      acc = rv1 && req_ready1;
      pop = rsp_valid1 && rsp_ready1;
      if (pop) begin
        if (exp_q.size() == 0) begin
          check_vec("t6_extra_rsp", 1, 0);
        end else begin
          check_vec("t6_data", rsp_data1, {2'b00, exp_q[0][17:2]});
          check_vec("t6_tag", rsp_tag1, exp_q[0][1:0]);
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (acc) exp_q.push_back({8'h00, ra1 & rb1, rt1});
      tick;
      if (acc) begin
        sent++;
        if (sent == 8) rv1 = 0;
        else begin
          ra1 = 8'($urandom); rb1 = 8'($urandom); rt1 = rt1 + 2'd1;
        end
      end
    end
    tick; tick; tick;
    check_vec("t6_sent", sent, 8);
    check_vec("t6_got", got, 8);
    check_vec("t6_drained", rsp_valid1, 0);
    rsp_ready1 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
